// File: rtl/text_console.sv
// ============================================================================
//  Module   : text_console
//  Purpose  : Character-stream writer for a 30x17 text-mode display. Accepts
//             ASCII bytes over valid/ready, tracks a cursor, interprets
//             CR/LF/BS/FF and writes {attr, chr} words into VRAM port A.
//             Owns screen clear, line wrap and wrap-around to the top row.
//  Ports    : clk_i, rst_i (async, active high)
//             chr_i[7:0], attr_i[7:0], chr_valid_i / chr_ready_o : byte input
//             clear_i           : one-cycle clear-screen + home request
//             vram_cea_o, vram_ada_o[9:0], vram_din_o[15:0] : VRAM write port
//             cursor_row_o[4:0], cursor_col_o[4:0] : next write position
//             busy_o            : high while any clear is in progress
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module text_console #(
    parameter int         COLS       = 30,
    parameter int         ROWS       = 17,
    parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  chr_i,
    input  logic [7:0]  attr_i,
    input  logic        chr_valid_i,
    output logic        chr_ready_o,
    input  logic        clear_i,
    output logic        vram_cea_o,
    output logic [9:0]  vram_ada_o,
    output logic [15:0] vram_din_o,
    output logic [4:0]  cursor_row_o,
    output logic [4:0]  cursor_col_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_ALL  = 2'd2
    } state_t;

    localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [15:0] BLANK    = {CLEAR_ATTR, 8'h20};

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  clr_row_q, clr_row_d;
    logic [4:0]  clr_col_q, clr_col_d;
    logic        cea_q, cea_d;
    logic [9:0]  ada_q, ada_d;
    logic [15:0] din_q, din_d;

    logic [4:0]  row_inc;

    // Row advance with wrap back to the top; there is no scrolling.
    assign row_inc = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLR_ALL;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            clr_row_q <= 5'd0;
            clr_col_q <= 5'd0;
            cea_q     <= 1'b0;
            ada_q     <= 10'd0;
            din_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            cea_q     <= cea_d;
            ada_q     <= ada_d;
            din_q     <= din_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        cea_d     = 1'b0;
        ada_d     = ada_q;
        din_d     = din_q;

        if (clear_i) begin
            // Restart a full clear from {0,0}; no write issues this cycle.
            state_d   = CLR_ALL;
            row_d     = 5'd0;
            col_d     = 5'd0;
            clr_row_d = 5'd0;
            clr_col_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chr_valid_i) begin
                        if (chr_i >= 8'h20 && chr_i <= 8'h7E) begin
                            cea_d = 1'b1;
                            ada_d = {row_q, col_q};
                            din_d = {attr_i, chr_i};
                            if (col_q == LAST_COL) begin
                                col_d     = 5'd0;
                                row_d     = row_inc;
                                clr_col_d = 5'd0;
                                state_d   = CLR_LINE;
                            end else begin
                                col_d = col_q + 5'd1;
                            end
                        end else begin
                            case (chr_i)
                                8'h0D: col_d = 5'd0;
                                8'h0A: begin
                                    col_d     = 5'd0;
                                    row_d     = row_inc;
                                    clr_col_d = 5'd0;
                                    state_d   = CLR_LINE;
                                end
                                8'h08: begin
                                    if (col_q != 5'd0) begin
                                        col_d = col_q - 5'd1;
                                        cea_d = 1'b1;
                                        ada_d = {row_q, col_q - 5'd1};
                                        din_d = BLANK;
                                    end
                                end
                                8'h0C: begin
                                    state_d   = CLR_ALL;
                                    row_d     = 5'd0;
                                    col_d     = 5'd0;
                                    clr_row_d = 5'd0;
                                    clr_col_d = 5'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                CLR_LINE: begin
                    // Cursor already sits on the row being blanked.
                    cea_d = 1'b1;
                    ada_d = {row_q, clr_col_q};
                    din_d = BLANK;
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = 5'd0;
                        state_d   = IDLE;
                    end else begin
                        clr_col_d = clr_col_q + 5'd1;
                    end
                end

                CLR_ALL: begin
                    cea_d = 1'b1;
                    ada_d = {clr_row_q, clr_col_q};
                    din_d = BLANK;
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = 5'd0;
                        if (clr_row_q == LAST_ROW) begin
                            clr_row_d = 5'd0;
                            state_d   = IDLE;
                        end else begin
                            clr_row_d = clr_row_q + 5'd1;
                        end
                    end else begin
                        clr_col_d = clr_col_q + 5'd1;
                    end
                end

                default: state_d = CLR_ALL;
            endcase
        end
    end

    assign chr_ready_o  = (state_q == IDLE) & ~clear_i;
    assign busy_o       = (state_q != IDLE);
    assign vram_cea_o   = cea_q;
    assign vram_ada_o   = ada_q;
    assign vram_din_o   = din_q;
    assign cursor_row_o = row_q;
    assign cursor_col_o = col_q;

endmodule

`default_nettype wire

// File: tb/tb_text_console.sv
// ============================================================================
//  Module   : tb_text_console
//  Purpose  : Directed self-checking bench for text_console.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_text_console;

    logic        clk;
    logic        rst;
    logic [7:0]  chr;
    logic [7:0]  attr;
    logic        valid;
    logic        ready;
    logic        clear;
    logic        cea;
    logic [9:0]  ada;
    logic [15:0] din;
    logic [4:0]  crow;
    logic [4:0]  ccol;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .chr_i        (chr),
        .attr_i       (attr),
        .chr_valid_i  (valid),
        .chr_ready_o  (ready),
        .clear_i      (clear),
        .vram_cea_o   (cea),
        .vram_ada_o   (ada),
        .vram_din_o   (din),
        .cursor_row_o (crow),
        .cursor_col_o (ccol),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        chr   = c;
        attr  = a;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Gather blank writes until ready returns, checking row-major order and data.
    task automatic collect(input logic [4:0] start_row, input bit all_rows,
                           output int n, output int bad, output logic [9:0] last);
        logic [4:0] er;
        logic [4:0] ec;
        er   = start_row;
        ec   = 5'd0;
        n    = 0;
        bad  = 0;
        last = 10'd0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cea) begin
                if (ada !== {er, ec} || din !== 16'h0720) bad++;
                last = ada;
                n++;
                if (ec == 5'd29) begin
                    ec = 5'd0;
                    if (all_rows) er = er + 5'd1;
                end else begin
                    ec = ec + 5'd1;
                end
            end
            if (ready) return;
        end
        checks++;
        errors++;
        $display("FAIL collect_timeout: got ready 0 expected 1");
    endtask

    int         n;
    int         bad;
    int         tot_n;
    int         tot_bad;
    logic [9:0] last;
    logic [7:0] c;

    initial begin
        rst   = 1'b1;
        chr   = 8'h00;
        attr  = 8'h00;
        valid = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cea",   32'(cea), 32'd0);
        chk("rst_ada",   32'(ada), 32'd0);
        chk("rst_din",   32'(din), 32'd0);
        chk("rst_row",   32'(crow), 32'd0);
        chk("rst_col",   32'(ccol), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd1);

        // Power-up clear: 510 blanks, row-major
        rst = 1'b0;
        collect(5'd0, 1'b1, n, bad, last);
        chk("init_writes", 32'(n), 32'd510);
        chk("init_bad",    32'(bad), 32'd0);
        chk("init_last",   32'(last), 32'h21D);
        chk("init_ready",  32'(ready), 32'd1);
        chk("init_busy",   32'(busy), 32'd0);
        chk("init_cursor", {crow, ccol}, 32'd0);

        // 'A' then back-to-back 'B'
        send(8'h41, 8'h9E);
        chk("A_cea",    32'(cea), 32'd1);
        chk("A_ada",    32'(ada), 32'h000);
        chk("A_din",    32'(din), 32'h9E41);
        chk("A_cursor", {crow, ccol}, {5'd0, 5'd1});
        send(8'h42, 8'h9E);
        chk("B_cea",    32'(cea), 32'd1);
        chk("B_ada",    32'(ada), 32'h001);
        chk("B_din",    32'(din), 32'h9E42);
        @(negedge clk);
        chk("hold_cea", 32'(cea), 32'd0);
        chk("hold_ada", 32'(ada), 32'h001);

        // CR back to column 0 with no write
        send(8'h0D, 8'h00);
        chk("cr_cea",    32'(cea), 32'd0);
        chk("cr_cursor", {crow, ccol}, {5'd0, 5'd0});

        // 30 printables on row 0 force a wrap and a row-1 clear
        for (int i = 0; i < 30; i++) begin
            c = 8'h41 + 8'(i % 26);
            send(c, 8'h1F);
        end
        chk("wrap_ada",    32'(ada), 32'h01D);
        chk("wrap_din",    32'(din), 32'h1F44);
        chk("wrap_cursor", {crow, ccol}, {5'd1, 5'd0});
        chk("wrap_ready",  32'(ready), 32'd0);
        collect(5'd1, 1'b0, n, bad, last);
        chk("wrap_clr_n",    32'(n), 32'd30);
        chk("wrap_clr_bad",  32'(bad), 32'd0);
        chk("wrap_clr_last", 32'(last), 32'h03D);

        // LF down to row 16
        tot_n   = 0;
        tot_bad = 0;
        for (int r = 2; r <= 16; r++) begin
            send(8'h0A, 8'h00);
            collect(5'(r), 1'b0, n, bad, last);
            tot_n   += n;
            tot_bad += bad;
        end
        chk("lf_total_n",   32'(tot_n), 32'd450);
        chk("lf_total_bad", 32'(tot_bad), 32'd0);
        chk("lf_row16",     {crow, ccol}, {5'd16, 5'd0});

        // LF at the bottom row wraps to row 0
        send(8'h0A, 8'h00);
        chk("lfwrap_cursor", {crow, ccol}, {5'd0, 5'd0});
        collect(5'd0, 1'b0, n, bad, last);
        chk("lfwrap_n",    32'(n), 32'd30);
        chk("lfwrap_bad",  32'(bad), 32'd0);
        chk("lfwrap_last", 32'(last), 32'h01D);

        // Move to 3,5 then exercise BS and CR
        for (int r = 1; r <= 3; r++) begin
            send(8'h0A, 8'h00);
            collect(5'(r), 1'b0, n, bad, last);
        end
        for (int i = 0; i < 5; i++) send(8'h61, 8'h02);
        chk("pos_3_5", {crow, ccol}, {5'd3, 5'd5});
        send(8'h08, 8'h55);
        chk("bs_cea",    32'(cea), 32'd1);
        chk("bs_ada",    32'(ada), 32'h064);
        chk("bs_din",    32'(din), 32'h0720);
        chk("bs_cursor", {crow, ccol}, {5'd3, 5'd4});
        send(8'h0D, 8'h00);
        chk("cr2_cursor", {crow, ccol}, {5'd3, 5'd0});
        send(8'h08, 8'h00);
        chk("bs0_cea",    32'(cea), 32'd0);
        chk("bs0_cursor", {crow, ccol}, {5'd3, 5'd0});
        chk("bs0_ada",    32'(ada), 32'h064);

        // Unhandled codes are consumed silently
        send(8'h01, 8'h00);
        send(8'h7F, 8'h00);
        send(8'hFF, 8'h00);
        chk("junk_cea",    32'(cea), 32'd0);
        chk("junk_cursor", {crow, ccol}, {5'd3, 5'd0});
        chk("junk_ready",  32'(ready), 32'd1);

        // clear_i mid-CLR_LINE with a byte pending
        send(8'h0A, 8'h00);
        repeat (5) @(negedge clk);
        chr   = 8'h5A;
        attr  = 8'h4F;
        valid = 1'b1;
        clear = 1'b1;
        #1;
        chk("clr_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        valid = 1'b0;
        chk("clr_cea",    32'(cea), 32'd0);
        chk("clr_cursor", {crow, ccol}, 32'd0);
        chk("clr_busy",   32'(busy), 32'd1);
        collect(5'd0, 1'b1, n, bad, last);
        chk("clr_n",     32'(n), 32'd510);
        chk("clr_bad",   32'(bad), 32'd0);
        chk("clr_last",  32'(last), 32'h21D);
        chk("clr_ready", 32'(ready), 32'd1);

        // FF behaves like clear_i
        send(8'h41, 8'h07);
        send(8'h0C, 8'h00);
        chk("ff_busy",   32'(busy), 32'd1);
        chk("ff_cursor", {crow, ccol}, 32'd0);
        collect(5'd0, 1'b1, n, bad, last);
        chk("ff_n",   32'(n), 32'd510);
        chk("ff_bad", 32'(bad), 32'd0);
        send(8'h43, 8'h70);
        chk("post_ff_ada", 32'(ada), 32'h000);
        chk("post_ff_din", 32'(din), 32'h7043);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_console.md
# text_console

Character-stream writer for the 30x17 text-mode video block. Accepts ASCII bytes over a valid/ready handshake, tracks a cursor, interprets a small set of control codes and writes character+attribute words into port A of the text VRAM (write side of the semi-dual-port RAM whose port B the video block scans). Owns screen clearing, line wrap and wrap-around to the top row. There is no read-back, so there is no scrolling.

## Interface
- COLS, 30, text columns per row (col range 0..COLS-1, max 32)
- ROWS, 17, text rows (row range 0..ROWS-1, max 32)
- CLEAR_ATTR, 8'h07, attribute byte written with blanks (blink 0, bg 000, fg 0111)

- clk_i  in  1  system clock; also drives VRAM port A (vram_clk_i)
- rst_i  in  1  asynchronous, active-high reset
- chr_i  in  8  character code
- attr_i  in  8  attribute {blink, bg[2:0], fg[3:0]}, sampled with chr_i
- chr_valid_i  in  1  chr_i/attr_i valid
- chr_ready_o  out  1  block can accept; transfer occurs when valid & ready at a rising edge
- clear_i  in  1  single-cycle request: clear screen and home cursor
- vram_cea_o  out  1  VRAM port A write enable, one cycle per word
- vram_ada_o  out  10  VRAM address {row[4:0], col[4:0]}
- vram_din_o  out  16  VRAM data {attr[7:0], chr[7:0]}
- cursor_row_o  out  5  row of the next write
- cursor_col_o  out  5  column of the next write
- busy_o  out  1  high in any clear state

## Operation
- States: IDLE, CLR_LINE, CLR_ALL. chr_ready_o = (state==IDLE) & ~clear_i. busy_o = ~(state==IDLE).
- Accepted byte in IDLE, by code:
  - 0x20..0x7E: write {attr_i, chr_i} at the cursor, then col+1. If col was COLS-1: col=0, row=row+1 (ROWS-1 wraps to 0), go to CLR_LINE.
  - 0x0D (CR): col=0. No write.
  - 0x0A (LF): col=0, row+1 with wrap, go to CLR_LINE.
  - 0x08 (BS): if col>0, col=col-1 and write {CLEAR_ATTR, 0x20} at the new col. If col is 0, nothing happens.
  - 0x0C (FF): same as clear_i.
  - Any other code (0x00..0x1F other than those above, 0x7F..0xFF): consumed, no effect.
- CLR_LINE: writes {CLEAR_ATTR, 0x20} to columns 0..COLS-1 of the new cursor row, one per cycle, in ascending order. Then returns to IDLE. The cursor already holds the new position during the clear.
- CLR_ALL: writes blanks to every row 0..ROWS-1 and column 0..COLS-1, row-major starting at {0,0}. Then goes to IDLE with the cursor at 0,0.
- clear_i is honoured in any state, including mid-CLR_LINE and mid-CLR_ALL (which restarts from {0,0}). It sets the cursor to 0,0 and takes priority over chr_valid_i in the same cycle.
- Addresses never exceed col COLS-1 or row ROWS-1. Unused address space (col 30,31; rows 17..31) is never written.

## Timing
- All outputs are registered. The write for a byte accepted at edge N has vram_cea_o=1 with valid ada/din during cycle N..N+1; the cursor updates at the same edge N.
- Printable/BS/CR throughput is 1 byte per clock. LF and line wrap cost COLS extra cycles with ready low. CLR_ALL takes ROWS*COLS cycles (510 at default).
- vram_cea_o is high for exactly one cycle per word. ada/din hold their last value when cea is low.
- Reset values: vram_cea_o=0, vram_ada_o=0, vram_din_o=0, cursor 0,0, state=CLR_ALL, so chr_ready_o=0 and busy_o=1.
- After reset deasserts, 510 blank writes occur, then chr_ready_o=1.
- Reset asserted mid-operation aborts immediately. The clear restarts from {0,0} on release.

## Test plan
- Reset release: exactly 510 cea pulses covering all addresses {r,c} with r<17 and c<30, each with din=16'h0720. Then ready=1 and cursor 0,0.
- Send 'A' (0x41) with attr 0x9E at cursor 0,0: next cycle cea=1, ada=10'h000, din=16'h9E41, cursor 0,1. Back-to-back 'B' (0x42) is accepted the next cycle at ada=10'h001.
- Send 30 printables on row 0: the 30th writes ada={0,29}. The cursor becomes 1,0, ready stays low 30 cycles while writing 16'h0720 to {1,0}..{1,29}.
- Cursor at row 16: send LF. The cursor becomes 0,0 and row 0 is cleared (30 writes, ada 10'h000..10'h01D).
- Cursor 3,5: send BS. Write at {3,4} with 16'h0720, cursor 3,4. Then CR moves to 3,0, and a BS at col 0 produces no write.
- Assert clear_i during CLR_LINE with chr_valid_i high: no byte is accepted that cycle, CLR_ALL restarts at {0,0}, and 510 writes follow.
